// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with guard (all anodes off) gaps and per-frame input snapshots.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZ_BLANK_EN.
module disp_scan_ctrl #(
  parameter int unsigned SHOW_CYC  = 50000,
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] hex_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  blank_in,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned MAX_CYC = (SHOW_CYC > GUARD_CYC) ? SHOW_CYC : GUARD_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   hex_q, hex_d;
  logic [3:0]    pt_q, pt_d;
  logic [3:0]    blk_q, blk_d;
  logic [3:0]    an_d;
  logic [3:0]    digit_d;
  logic          dp_d;
  logic          tick_d;
  logic [3:0]    lz_blank_d;
  logic          blanked_d;

`ifdef DISP_SCAN_LZ_BLANK_EN
  // Digit k blanks when it and every more-significant nibble is zero; digit 0 always shows.
  always_comb begin
    lz_blank_d    = 4'b0000;
    lz_blank_d[3] = (hex_d[15:12] == 4'd0);
    lz_blank_d[2] = lz_blank_d[3] && (hex_d[11:8] == 4'd0);
    lz_blank_d[1] = lz_blank_d[2] && (hex_d[7:4] == 4'd0);
  end
`else
  assign lz_blank_d = 4'b0000;
`endif

  // Next-state and output decode; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    hex_d   = hex_q;
    pt_d    = pt_q;
    blk_d   = blk_q;
    tick_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sel_d = 2'd0;
        if (en) begin
          state_d = GUARD;
          hex_d   = hex_in;
          pt_d    = point_in;
          blk_d   = blank_in;
        end
      end
      GUARD: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end else if (cnt_q == CW'(GUARD_CYC - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end else if (cnt_q == CW'(SHOW_CYC - 1)) begin
          state_d = GUARD;
          cnt_d   = '0;
          sel_d   = sel_q + 2'd1;
          if (sel_q == 2'd3) begin
            tick_d = 1'b1;
            hex_d  = hex_in;
            pt_d   = point_in;
            blk_d  = blank_in;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = 2'd0;
      end
    endcase

    blanked_d = blk_d[sel_d] | lz_blank_d[sel_d];
    an_d      = 4'b1111;
    digit_d   = 4'd0;
    dp_d      = 1'b0;
    if (state_d != IDLE) begin
      digit_d = 4'(hex_d >> {sel_d, 2'b00});
      dp_d    = pt_d[sel_d] & ~blanked_d;
      if (state_d == SHOW && !blanked_d) begin
        an_d = ~(4'b0001 << sel_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= 2'd0;
      hex_q      <= 16'd0;
      pt_q       <= 4'd0;
      blk_q      <= 4'd0;
      an         <= 4'b1111;
      digit      <= 4'd0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      hex_q      <= hex_d;
      pt_q       <= pt_d;
      blk_q      <= blk_d;
      an         <= an_d;
      digit      <= digit_d;
      dp         <= dp_d;
      frame_tick <= tick_d;
    end
  end

  assign sel = sel_q;

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYC, default 50000: cycles a digit's anode is driven per slot (>=1).
REQ-002 SHALL have parameter GUARD_CYC, default 16: anti-ghosting cycles with all anodes off before each slot (>=1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port en, input, 1, scan enable.
REQ-006 SHALL have port hex_in, input, 16, four BCD/hex nibbles; [3:0] is digit 0 (rightmost).
REQ-007 SHALL have port point_in, input, 4, decimal point request per digit.
REQ-008 SHALL have port blank_in, input, 4, force-blank request per digit.
REQ-009 SHALL have port sel, output, 2, digit select driving the 4:1 digit mux select inputs.
REQ-010 SHALL have port an, output, 4, anode enables, active-low.
REQ-011 SHALL have port digit, output, 4, nibble of the currently selected digit.
REQ-012 SHALL have port dp, output, 1, decimal point for the selected digit, active-high.
REQ-013 SHALL have port frame_tick, output, 1, one-cycle pulse at the end of each full 4-digit frame.

Function
REQ-014 SHALL implement FSM states IDLE, GUARD, SHOW, with one cycle counter shared by GUARD and SHOW.
REQ-015 IDLE: an=4'b1111, sel=0, counter=0; when en=1, SHALL capture hex_in, point_in and blank_in into snapshot registers and go to GUARD with sel=0.
REQ-016 GUARD SHALL last exactly GUARD_CYC cycles with an=4'b1111, then go to SHOW with the counter cleared.
REQ-017 SHOW SHALL last exactly SHOW_CYC cycles with an[sel]=0 and other bits 1, unless the digit is blanked (REQ-021), in which case an=4'b1111.
REQ-018 At the end of SHOW, sel SHALL increment modulo 4 and the FSM SHALL go to GUARD; sel SHALL change only on this transition.
REQ-019 On the wrap from sel=3 to sel=0, frame_tick SHALL pulse for exactly one cycle (the first GUARD cycle of the new frame), and the snapshot SHALL be reloaded on that same edge.
REQ-020 Snapshots SHALL change only at frame start, so input changes mid-frame never produce a torn display.
REQ-021 A digit SHALL be blanked when its snapshot blank bit is 1 (plus REQ-030 when enabled).
REQ-022 digit SHALL equal snapshot nibble[sel] and dp SHALL equal snapshot point[sel]; both SHALL be held in GUARD, and dp SHALL be 0 when the digit is blanked.
REQ-023 All outputs SHALL be registered; slot length SHALL be GUARD_CYC+SHOW_CYC cycles and frame length 4*(GUARD_CYC+SHOW_CYC).
REQ-024 If en falls in any state, the FSM SHALL return to IDLE on the next edge with an=4'b1111 and sel=0, and no frame_tick SHALL be generated.
REQ-025 If en rises again, the scan SHALL restart from digit 0 with a fresh snapshot.
REQ-026 The counter SHALL be wide enough for max(SHOW_CYC, GUARD_CYC) and SHALL never wrap within a state.

Reset
REQ-027 On rst=1 at a clock edge, regardless of en, the block SHALL set: state IDLE; counter 0; sel 0; an 4'b1111; digit 0; dp 0; frame_tick 0; snapshots 0.
REQ-028 rst SHALL take priority over en and over any in-progress slot; the first GUARD SHALL begin no earlier than the edge after rst deasserts with en=1.

Configuration
REQ-029 SHALL support macro DISP_SCAN_LZ_BLANK_EN.
REQ-030 With DISP_SCAN_LZ_BLANK_EN defined: digit k (k=3,2,1) SHALL also be blanked when the snapshot nibbles k..3 are all zero; digit 0 is never auto-blanked.
REQ-031 Without the macro: only blank_in blanks digits, and no leading-zero logic is synthesized.

Verification (SHOW_CYC=4, GUARD_CYC=2)
REQ-032 Reset then en=1, hex_in=16'h1234: sel steps 0,1,2,3 every 6 cycles; an pattern per slot is 1111 x2 then 1110/1101/1011/0111 x4; digit=4,3,2,1.
REQ-033 frame_tick SHALL be high for exactly one cycle every 24 cycles, coincident with sel returning to 0.
REQ-034 Change hex_in to 16'hABCD during sel=1 SHOW: the rest of the frame still shows 3,2,1; the next frame shows D,C,B,A.
REQ-035 blank_in=4'b0100, point_in=4'b0001: an stays 1111 during the digit 2 slot; dp=1 only in the sel=0 slot.
REQ-036 Drop en or assert rst mid-SHOW of sel=2: next cycle an=1111, sel=0, no frame_tick; re-enable restarts at digit 0 after 2 guard cycles.
REQ-037 With DISP_SCAN_LZ_BLANK_EN and hex_in=16'h0050: digits 3 and 2 are blanked, digits 1 and 0 are shown; with hex_in=16'h0000 only digit 0 is shown.
